// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// Optional port sub exists only when PIPELINED_ADDER_SUB_EN is defined.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPELINED_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
`ifdef PIPELINED_ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder: stage k adds slice k with the carry registered by stage k-1.
// Define PIPELINED_ADDER_SUB_EN to add the sub port (a - b, cin ignored).
module pipelined_adder #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  pipelined_adder_if.slave bus_io
);
  localparam int unsigned CW  = WIDTH / STAGES;
  localparam int unsigned MSB = WIDTH - 1;

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic                         ovf_q, ovf_d;
  logic                         advance;

  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in;
  logic [STAGES-1:0]            c_in, v_in;
  logic [STAGES-1:0][CW:0]      slice;
  logic [WIDTH-1:0]             b_eff;
  logic                         cin_eff;

  // Subtraction is folded into the operands at entry so it travels with them.
`ifdef PIPELINED_ADDER_SUB_EN
  assign b_eff   = bus_io.sub ? ~bus_io.b : bus_io.b;
  assign cin_eff = bus_io.sub | bus_io.cin;
`else
  assign b_eff   = bus_io.b;
  assign cin_eff = bus_io.cin;
`endif

  assign advance = !valid_q[STAGES-1] || bus_io.out_ready;

  always_comb begin
    a_in    = '0;
    b_in    = '0;
    s_in    = '0;
    c_in    = '0;
    v_in    = '0;
    slice   = '0;
    a_d     = '0;
    b_d     = '0;
    s_d     = '0;
    carry_d = '0;
    valid_d = '0;
    a_in[0] = bus_io.a;
    b_in[0] = b_eff;
    c_in[0] = cin_eff;
    v_in[0] = bus_io.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = carry_q[k-1];
      v_in[k] = valid_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice[k] = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
               + (CW+1)'(c_in[k]);
      a_d[k]                = a_in[k];
      b_d[k]                = b_in[k];
      s_d[k]                = s_in[k];
      s_d[k][k*CW +: CW]    = slice[k][CW-1:0];
      carry_d[k]            = slice[k][CW];
      valid_d[k]            = v_in[k];
    end
    // Carry into the MSB is recovered from the MSB's own sum bit.
    ovf_d = carry_d[STAGES-1] ^ a_in[STAGES-1][MSB] ^ b_in[STAGES-1][MSB]
          ^ s_d[STAGES-1][MSB];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
    end else if (advance) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_io.in_ready  = advance;
  assign bus_io.out_valid = valid_q[STAGES-1];
  assign bus_io.sum       = s_q[STAGES-1];
  assign bus_io.cout      = carry_q[STAGES-1];
  assign bus_io.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=24, STAGES=4).
// Sub test runs only when PIPELINED_ADDER_SUB_EN is defined.
module tb_pipelined_adder;
  localparam int unsigned W = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus ();
  pipelined_adder #(.WIDTH(W), .STAGES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nfail = 0;
  int          cyc = 0;
  bit          lat_en;
  logic [3:0]  vhist;
  bit          hold_pend;
  logic [31:0] prev;
  logic        cur_sub;

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic c, logic s);
    exp_t         e;
    logic [W:0]   r;
    logic [W-1:0] be;
    logic         ce;
    be     = s ? ~b : b;
    ce     = s ? 1'b1 : c;
    r      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    e.cyc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    cur_sub      = s;
`ifdef PIPELINED_ADDER_SUB_EN
    bus.sub      = s;
`endif
  endtask

  // Checks outputs, scores the transfer decided for the coming edge, then steps past it.
  task automatic sample_and_edge();
    exp_t e;
    logic xfer;
    check("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
    if (hold_pend) check("hold", {5'b0, bus.out_valid, bus.ovf, bus.cout, bus.sum}, prev);
    if (lat_en) check("valid_seq", 32'(bus.out_valid), 32'(vhist[3]));
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(bus.out_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        check("sum", 32'(bus.sum), 32'(e.sum));
        check("cout", 32'(bus.cout), 32'(e.cout));
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
        if (e.lat) check("latency", 32'(cyc - e.cyc), 32'(4));
      end
    end
    xfer = bus.in_valid && bus.in_ready;
    if (xfer) begin
      e     = model(bus.a, bus.b, bus.cin, cur_sub);
      e.cyc = cyc;
      e.lat = lat_en;
      sb.push_back(e);
    end
    hold_pend = bus.out_valid && !bus.out_ready;
    prev      = {5'b0, bus.out_valid, bus.ovf, bus.cout, bus.sum};
    vhist     = {vhist[2:0], xfer};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample_and_edge();
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && sb.size() > 0; i++) cycle();
    check("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  logic [W-1:0] ra[10];
  logic [W-1:0] rb[10];
  logic         rc[10];

  initial begin
    int i;
    int nstall;
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    lat_en    = 1'b0;
    vhist     = '0;
    hold_pend = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_sum", 32'(bus.sum), 32'(0));
    check("rst_cout", 32'(bus.cout), 32'(0));
    check("rst_ovf", 32'(bus.ovf), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    #7 rst = 1'b0;
    @(posedge clk);
    #1;
    lat_en = 1'b1;

    // Carry ripples through every stage boundary.
    drive(1'b1, 24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (5) cycle();

    drive(1'b1, 24'h7FFFFF, 24'h000001, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 24'h800000, 24'h800000, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 24'hAAAAAA, 24'h555555, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 24'h000000, 24'h000000, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (6) cycle();

    // Alternating valid must reappear four cycles later.
    for (int k = 0; k < 4; k++) begin
      drive(((k % 2) == 0), W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (6) cycle();

    // Back-to-back stream with a three-cycle downstream stall.
    for (int k = 0; k < 10; k++) begin
      ra[k] = W'($urandom);
      rb[k] = W'($urandom);
      rc[k] = 1'($urandom);
    end
    lat_en = 1'b0;
    i      = 0;
    nstall = 0;
    for (int t = 0; t < 40 && i < 10; t++) begin
      drive(1'b1, ra[i], rb[i], rc[i], 1'b0);
      bus.out_ready = !(t >= 6 && t < 9);
      @(negedge clk);
      if (!bus.in_ready) nstall++;
      if (bus.in_valid && bus.in_ready) i++;
      sample_and_edge();
    end
    check("ops_accepted", 32'(i), 32'(10));
    check("stall_cycles", 32'(nstall), 32'(3));
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drain(20);
    repeat (2) cycle();
    vhist  = '0;
    lat_en = 1'b1;

`ifdef PIPELINED_ADDER_SUB_EN
    drive(1'b1, 24'h000005, 24'h000007, 1'b1, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (5) cycle();
`endif

    // Reset mid-flight discards everything; first edge after release accepts.
    drive(1'b1, 24'h111111, 24'h000001, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 24'h222222, 24'h000002, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 24'h333333, 24'h000003, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    check("pre_rst_valid", 32'(bus.out_valid), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'(0));
    check("async_rst_sum", 32'(bus.sum), 32'(0));
    check("async_rst_cout", 32'(bus.cout), 32'(0));
    check("async_rst_ovf", 32'(bus.ovf), 32'(0));
    check("async_rst_in_ready", 32'(bus.in_ready), 32'(1));
    sb.delete();
    vhist     = '0;
    hold_pend = 1'b0;
    #4 rst = 1'b0;
    drive(1'b1, 24'hABCDEF, 24'h123456, 1'b1, 1'b0);
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
    sample_and_edge();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drain(10);
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
